// File: rtl/sys_bus_ctrl.sv
// -----------------------------------------------------------------------------
// sys_bus_ctrl -- single-master to N-slave bus controller.
//
// One master transaction at a time is decoded by the top SEL_W address bits
// and forwarded to the selected slave. The controller holds the request until
// that slave reports ready, then returns a one-cycle response to the master.
// Addresses that decode past the last slave get an immediate error response.
//
// Optional feature macro: SYS_BUS_TIMEOUT_EN
//   defined   : a 16-bit WAIT counter aborts a stalled slave access after
//               TIMEOUT cycles with an error response.
//   undefined : no counter exists; WAIT lasts until the slave is ready.
//
// Reset is synchronous and active-low (rst_i). All outputs are registers.
// -----------------------------------------------------------------------------
module sys_bus_ctrl #(
  parameter int N_SLAVES = 4,
  parameter int SEL_W    = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // master side
  input  logic                  m_req_i,
  input  logic                  m_we_i,
  input  logic [3:0]            m_be_i,
  input  logic [31:0]           m_addr_i,
  input  logic [31:0]           m_wd_i,
  output logic [31:0]           m_rd_o,
  output logic                  m_ready_o,
  output logic                  m_err_o,
  // slave side
  output logic [N_SLAVES-1:0]   s_req_o,
  output logic                  s_we_o,
  output logic [3:0]            s_be_o,
  output logic [31:0]           s_addr_o,
  output logic [31:0]           s_wd_o,
  input  logic [32*N_SLAVES-1:0] s_rd_i,
  input  logic [N_SLAVES-1:0]   s_ready_i
);

  // FSM encoding kept as plain constants so the state vector can be probed
  // and compared against legacy traces.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Slave count widened by one bit so the decode compare never truncates,
  // even when N_SLAVES == 2**SEL_W.
  localparam logic [SEL_W:0] W_NSLV = (SEL_W + 1)'(N_SLAVES);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [1:0]          r_state;
  logic [SEL_W-1:0]    r_idx;
  logic [31:0]         r_addr;
  logic                r_we;
  logic [3:0]          r_be;
  logic [31:0]         r_wd;
  logic [N_SLAVES-1:0] r_s_req;
  logic                r_m_ready;
  logic                r_m_err;
  logic [31:0]         r_m_rd;

  // ---------------------------------------------------------------------------
  // Combinational decode / selection
  // ---------------------------------------------------------------------------
  logic [SEL_W-1:0]    w_idx;
  logic                w_hit;
  logic [N_SLAVES-1:0] w_onehot;
  logic                w_sel_ready;
  logic [31:0]         w_sel_rd;
  logic                w_accept;

  // Slave index comes from the top SEL_W bits of the incoming address.
  assign w_idx    = m_addr_i[31 -: SEL_W];
  assign w_hit    = ({1'b0, w_idx} < W_NSLV);
  assign w_accept = (r_state == ST_IDLE) && m_req_i;

`ifdef SYS_BUS_TIMEOUT_EN
  localparam logic [15:0] W_TIMEOUT = 16'(TIMEOUT);
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;
  logic        w_timeout;

  // Count of WAIT cycles seen so far including the current one.
  assign w_cnt_nxt = r_cnt + 16'd1;
  assign w_timeout = (w_cnt_nxt == W_TIMEOUT);
`else
  // TIMEOUT only matters when the counter is built; keep it referenced.
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT == 0);
`endif

  // Build the one-hot request for the address currently offered by the master.
  always_comb begin
    w_onehot = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (w_idx == SEL_W'(k)) begin
        w_onehot[k] = 1'b1;
      end else begin
        w_onehot[k] = 1'b0;
      end
    end
  end

  // Pick the ready bit and read-data slice of the latched slave; all other
  // slaves' ready and data are ignored here.
  always_comb begin
    w_sel_ready = 1'b0;
    w_sel_rd    = 32'h0000_0000;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (r_idx == SEL_W'(k)) begin
        w_sel_ready = s_ready_i[k];
        w_sel_rd    = s_rd_i[32*k +: 32];
      end else begin
        w_sel_ready = w_sel_ready;
        w_sel_rd    = w_sel_rd;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------

  // Latch the master request fields when a transaction is accepted in IDLE;
  // they then drive the shared slave bus unchanged until the next accept.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_idx  <= '0;
      r_addr <= 32'h0000_0000;
      r_we   <= 1'b0;
      r_be   <= 4'h0;
      r_wd   <= 32'h0000_0000;
    end else if (w_accept) begin
      r_idx  <= w_idx;
      r_addr <= m_addr_i;
      r_we   <= m_we_i;
      r_be   <= m_be_i;
      r_wd   <= m_wd_i;
    end else begin
      r_idx  <= r_idx;
      r_addr <= r_addr;
      r_we   <= r_we;
      r_be   <= r_be;
      r_wd   <= r_wd;
    end
  end

  // Transaction FSM together with its registered slave-request and master
  // response outputs, so every output changes on the same edge as the state.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state   <= ST_IDLE;
      r_s_req   <= '0;
      r_m_ready <= 1'b0;
      r_m_err   <= 1'b0;
      r_m_rd    <= 32'h0000_0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (m_req_i && w_hit) begin
            r_state   <= ST_WAIT;
            r_s_req   <= w_onehot;
            r_m_ready <= 1'b0;
            r_m_err   <= 1'b0;
            r_m_rd    <= 32'h0000_0000;
          end else if (m_req_i) begin
            // Decode miss: no slave is touched, answer with an error now.
            r_state   <= ST_RESP;
            r_s_req   <= '0;
            r_m_ready <= 1'b1;
            r_m_err   <= 1'b1;
            r_m_rd    <= 32'h0000_0000;
          end else begin
            r_state   <= ST_IDLE;
            r_s_req   <= '0;
            r_m_ready <= 1'b0;
            r_m_err   <= 1'b0;
            r_m_rd    <= 32'h0000_0000;
          end
        end
        ST_WAIT: begin
          if (w_sel_ready) begin
            // Ready wins over a simultaneous timeout. Writes return zero.
            r_state   <= ST_RESP;
            r_s_req   <= '0;
            r_m_ready <= 1'b1;
            r_m_err   <= 1'b0;
            r_m_rd    <= r_we ? 32'h0000_0000 : w_sel_rd;
`ifdef SYS_BUS_TIMEOUT_EN
          end else if (w_timeout) begin
            r_state   <= ST_RESP;
            r_s_req   <= '0;
            r_m_ready <= 1'b1;
            r_m_err   <= 1'b1;
            r_m_rd    <= 32'h0000_0000;
`endif
          end else begin
            r_state   <= ST_WAIT;
            r_s_req   <= r_s_req;
            r_m_ready <= 1'b0;
            r_m_err   <= 1'b0;
            r_m_rd    <= 32'h0000_0000;
          end
        end
        ST_RESP: begin
          // Response lasts exactly one cycle; master inputs are not sampled.
          r_state   <= ST_IDLE;
          r_s_req   <= '0;
          r_m_ready <= 1'b0;
          r_m_err   <= 1'b0;
          r_m_rd    <= 32'h0000_0000;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_s_req   <= '0;
          r_m_ready <= 1'b0;
          r_m_err   <= 1'b0;
          r_m_rd    <= 32'h0000_0000;
        end
      endcase
    end
  end

`ifdef SYS_BUS_TIMEOUT_EN
  // WAIT-cycle counter: cleared on every accept so each access starts at
  // zero, advanced on each WAIT cycle that passes without ready.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_cnt <= 16'd0;
    end else if (w_accept) begin
      r_cnt <= 16'd0;
    end else if ((r_state == ST_WAIT) && !w_sel_ready) begin
      r_cnt <= w_cnt_nxt;
    end else begin
      r_cnt <= r_cnt;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign s_req_o   = r_s_req;
  assign s_we_o    = r_we;
  assign s_be_o    = r_be;
  assign s_addr_o  = r_addr;
  assign s_wd_o    = r_wd;
  assign m_ready_o = r_m_ready;
  assign m_err_o   = r_m_err;
  assign m_rd_o    = r_m_rd;

endmodule

// File: tb/tb_sys_bus_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for sys_bus_ctrl: directed scenarios followed by randomized
// transactions, all checked against a transaction-level reference model.
// With SYS_BUS_TIMEOUT_EN defined the model also applies the timeout rule.
// -----------------------------------------------------------------------------
module tb_sys_bus_ctrl;

  localparam int NS = 4;
  localparam int SW = 4;
  localparam int TO = 8;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            m_req_i;
  logic            m_we_i;
  logic [3:0]      m_be_i;
  logic [31:0]     m_addr_i;
  logic [31:0]     m_wd_i;
  logic [31:0]     m_rd_o;
  logic            m_ready_o;
  logic            m_err_o;
  logic [NS-1:0]   s_req_o;
  logic            s_we_o;
  logic [3:0]      s_be_o;
  logic [31:0]     s_addr_o;
  logic [31:0]     s_wd_o;
  logic [32*NS-1:0] s_rd_i;
  logic [NS-1:0]   s_ready_i;

  int n_cmp = 0;
  int n_err = 0;

  sys_bus_ctrl #(.N_SLAVES(NS), .SEL_W(SW), .TIMEOUT(TO)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .m_req_i   (m_req_i),
    .m_we_i    (m_we_i),
    .m_be_i    (m_be_i),
    .m_addr_i  (m_addr_i),
    .m_wd_i    (m_wd_i),
    .m_rd_o    (m_rd_o),
    .m_ready_o (m_ready_o),
    .m_err_o   (m_err_o),
    .s_req_o   (s_req_o),
    .s_we_o    (s_we_o),
    .s_be_o    (s_be_o),
    .s_addr_o  (s_addr_o),
    .s_wd_o    (s_wd_o),
    .s_rd_i    (s_rd_i),
    .s_ready_i (s_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic rand_slaves();
    s_ready_i = NS'($urandom);
    for (int k = 0; k < NS; k++) s_rd_i[32*k +: 32] = $urandom;
  endtask

  // Advance to the middle of the next cycle's drive window.
  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // One master transaction. waitn = slave wait cycles before ready.
  // Expected behaviour comes from the rules: decode miss -> error at cycle 1;
  // hit -> response at cycle waitn+2 (or timeout at cycle TO+1 if enabled).
  task automatic run_txn(input logic [31:0] addr, input logic we, input logic [3:0] be,
                         input logic [31:0] wd, input int waitn, input logic [31:0] rdata);
    int            idx;
    logic          hit;
    int            lat;
    logic          exp_err;
    logic [31:0]   exp_rd;
    logic [NS-1:0] exp_req;
    idx = int'(addr[31:28]);
    hit = (idx < NS);
    exp_req = '0;
    if (hit) exp_req[idx] = 1'b1;
    if (!hit) begin
      lat = 1; exp_err = 1'b1; exp_rd = 32'h0;
    end else begin
      lat = waitn + 2; exp_err = 1'b0; exp_rd = we ? 32'h0 : rdata;
`ifdef SYS_BUS_TIMEOUT_EN
      if (waitn >= TO) begin
        lat = TO + 1; exp_err = 1'b1; exp_rd = 32'h0;
      end
`endif
    end
    // cycle 0: present the request in IDLE
    m_req_i = 1'b1; m_we_i = we; m_be_i = be; m_addr_i = addr; m_wd_i = wd;
    rand_slaves();
    next_cycle();
    // master inputs must be ignored from here on
    m_req_i = 1'b0; m_we_i = 1'($urandom); m_be_i = 4'($urandom);
    m_addr_i = $urandom; m_wd_i = $urandom;
    for (int c = 1; c <= lat; c++) begin
      rand_slaves();
      if (hit) begin
        s_rd_i[32*idx +: 32] = rdata;
        s_ready_i[idx] = (c == waitn + 1);
      end
      @(negedge clk_i);
      if (c < lat) begin
        chk("wait_req",   32'(s_req_o),   32'(exp_req));
        chk("wait_ready", 32'(m_ready_o), 32'h0);
        chk("wait_rd",    m_rd_o,         32'h0);
        chk("s_addr",     s_addr_o,       addr);
        chk("s_we",       32'(s_we_o),    32'(we));
        chk("s_be",       32'(s_be_o),    32'(be));
        chk("s_wd",       s_wd_o,         wd);
      end else begin
        chk("resp_ready", 32'(m_ready_o), 32'h1);
        chk("resp_err",   32'(m_err_o),   32'(exp_err));
        chk("resp_rd",    m_rd_o,         exp_rd);
        chk("resp_req",   32'(s_req_o),   32'h0);
      end
      next_cycle();
    end
    // back in IDLE: response must be gone
    rand_slaves();
    @(negedge clk_i);
    chk("idle_ready", 32'(m_ready_o), 32'h0);
    chk("idle_err",   32'(m_err_o),   32'h0);
    chk("idle_rd",    m_rd_o,         32'h0);
    chk("idle_req",   32'(s_req_o),   32'h0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    rst_i = 1'b0; m_req_i = 1'b0; m_we_i = 1'b0; m_be_i = 4'h0;
    m_addr_i = 32'h0; m_wd_i = 32'h0; s_rd_i = '0; s_ready_i = '0;

    // reset state
    next_cycle(); next_cycle();
    @(negedge clk_i);
    chk("rst_ready", 32'(m_ready_o), 32'h0);
    chk("rst_err",   32'(m_err_o),   32'h0);
    chk("rst_rd",    m_rd_o,         32'h0);
    chk("rst_req",   32'(s_req_o),   32'h0);
    chk("rst_addr",  s_addr_o,       32'h0);
    chk("rst_wd",    s_wd_o,         32'h0);
    chk("rst_be",    32'(s_be_o),    32'h0);
    chk("rst_we",    32'(s_we_o),    32'h0);
    rst_i = 1'b1;
    next_cycle();

    // directed: read slave1, write slave0 with 3 waits, decode miss
    run_txn(32'h1000_0010, 1'b0, 4'hF, 32'h0, 0, 32'hDEAD_BEEF);
    run_txn(32'h0000_0004, 1'b1, 4'b0011, 32'h1234_5678, 3, 32'hCAFE_F00D);
    run_txn(32'hF000_0000, 1'b0, 4'hF, 32'h0, 0, 32'h5555_AAAA);
    // long stall (times out when the counter is built), ready on TO-th cycle
    run_txn(32'h2000_0000, 1'b0, 4'hF, 32'h0, 20, 32'h0BAD_CAFE);
    run_txn(32'h2000_0040, 1'b0, 4'hF, 32'h0, TO - 1, 32'h1357_9BDF);

    // reset on the second WAIT cycle of a read to slave3
    m_req_i = 1'b1; m_we_i = 1'b0; m_be_i = 4'hF; m_addr_i = 32'h3000_0008; m_wd_i = 32'h0;
    s_ready_i = '0;
    next_cycle();
    m_req_i = 1'b0;
    @(negedge clk_i);
    chk("rstw_req1", 32'(s_req_o), 32'h8);
    next_cycle();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rstw_req2", 32'(s_req_o), 32'h8);
    next_cycle();
    rst_i = 1'b1;
    s_ready_i = '1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      chk("rstw_req0",  32'(s_req_o),   32'h0);
      chk("rstw_noack", 32'(m_ready_o), 32'h0);
      next_cycle();
    end
    run_txn(32'h3000_0008, 1'b0, 4'hF, 32'h0, 1, 32'h0F0F_0F0F);

    // back-to-back with m_req_i held high and spurious ready everywhere
    d = 32'hA5A5_5A5A;
    @(negedge clk_i);
    m_req_i = 1'b1; m_we_i = 1'b0; m_be_i = 4'hF; m_addr_i = 32'h0000_0100;
    s_ready_i = '1;
    s_rd_i[31:0] = d;
    for (int c = 1; c <= 9; c++) begin
      next_cycle();
      @(negedge clk_i);
      chk("b2b_ready", 32'(m_ready_o), (c % 3 == 2) ? 32'h1 : 32'h0);
      chk("b2b_rd",    m_rd_o,         (c % 3 == 2) ? d : 32'h0);
      chk("b2b_req",   32'(s_req_o),   (c % 3 == 1) ? 32'h1 : 32'h0);
    end
    m_req_i = 1'b0;
    s_ready_i = '0;
    next_cycle();

    // randomized transactions
    for (int t = 0; t < 40; t++) begin
      a = $urandom;
      run_txn(a, 1'($urandom), 4'($urandom), $urandom, $urandom_range(0, 10), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
